// File: rtl/data_sram_resp.sv
// data_sram_resp: single-port 32-bit data SRAM with byte write enables and a
// registered, one-cycle-pulsed read response.
//
// Optional feature macro: DATA_SRAM_WAIT_EN
//   undefined : every request is performed in its accept cycle, no stalls.
//   defined   : IDLE/WAIT state machine stretches each access to WAIT_CYCLES
//               cycles and raises stallreq_for_mem while the access is pending.
//
// Ports:
//   clk              - clock, all state updates on posedge
//   rst              - synchronous active-high reset (storage is not cleared)
//   data_sram_en     - access request valid
//   data_sram_wen    - byte write enables, 4'b0000 means read
//   data_sram_addr   - byte address, word index = addr[ADDR_W+1:2]
//   data_sram_wdata  - write data (lane-replicated by the initiator)
//   data_sram_rdata  - registered read data, held until the next read response
//   resp_valid       - one-cycle pulse marking a read response
//   stallreq_for_mem - combinational pipeline stall while an access is pending

module data_sram_resp #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        resp_valid,
    output logic        stallreq_for_mem
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] in_idx;
    logic              unused_addr_bits;

    // Access actually performed at the end of this cycle
    logic              do_access;
    logic [ADDR_W-1:0] acc_idx;
    logic [3:0]        acc_wen;
    logic [31:0]       acc_wdata;

    // Byte offset and high address bits alias onto the same word
    assign in_idx           = data_sram_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

`ifdef DATA_SRAM_WAIT_EN

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [3:0]        wen;
        logic [31:0]       wdata;
    } access_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    access_t           lat, lat_nxt;
    logic              stall_c;

    // State, counter and latched-access registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            lat   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lat   <= lat_nxt;
        end
    end

    // Next state. The counter holds the stall cycles still to come, so the
    // latched access fires in the WAIT cycle where it steps from 1 to 0; this
    // keeps the stall window at exactly WAIT_CYCLES cycles including accept.
    // WAIT_CYCLES of 0 or 1 performs the access in the accept cycle itself.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat_nxt   = lat;
        stall_c   = 1'b0;
        do_access = 1'b0;
        acc_idx   = in_idx;
        acc_wen   = data_sram_wen;
        acc_wdata = data_sram_wdata;
        case (state)
            IDLE: begin
                if (data_sram_en) begin
                    if (WAIT_CYCLES >= 2) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                        lat_nxt   = '{idx: in_idx, wen: data_sram_wen, wdata: data_sram_wdata};
                        stall_c   = 1'b1;
                    end else begin
                        do_access = 1'b1;
                        stall_c   = (WAIT_CYCLES == 1);
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    do_access = 1'b1;
                    acc_idx   = lat.idx;
                    acc_wen   = lat.wen;
                    acc_wdata = lat.wdata;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign stallreq_for_mem = stall_c & ~rst;

`else

    // Fixed single-cycle behaviour: every request is accepted immediately
    assign do_access        = data_sram_en;
    assign acc_idx          = in_idx;
    assign acc_wen          = data_sram_wen;
    assign acc_wdata        = data_sram_wdata;
    assign stallreq_for_mem = 1'b0;

`endif

    // Storage: byte-lane writes, never reset
    always_ff @(posedge clk) begin
        if (!rst && do_access) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read response: data and a one-cycle valid pulse; data held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sram_rdata <= '0;
            resp_valid      <= 1'b0;
        end else begin
            resp_valid <= do_access && (acc_wen == 4'b0000);
            if (do_access && (acc_wen == 4'b0000)) begin
                data_sram_rdata <= mem[acc_idx];
            end
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: a vector table driven through a
// read-data scoreboard for the single-cycle build, plus hand-written
// sequences for reset corners and, when DATA_SRAM_WAIT_EN is defined, the
// wait-state timing.

module tb_data_sram_resp;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] last_rdata;

    data_sram_resp #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_sram_en     (en),
        .data_sram_wen    (wen),
        .data_sram_addr   (addr),
        .data_sram_wdata  (wdata),
        .data_sram_rdata  (rdata),
        .resp_valid       (resp_valid),
        .stallreq_for_mem (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present inputs on the falling edge, well away from the active edge
    task automatic drive(input logic r, input logic e, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst   = r;
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
    endtask

    // Advance through the next active edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifndef DATA_SRAM_WAIT_EN
    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_valid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[18];
`else
    // Read with wait states: stall in the accept and following cycle, response after two edges
    task automatic wait_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b0, 1'b1, 4'h0, a, 32'h0);
        #1 check({name, "_stall_acc"}, 32'(stall), 32'd1);
        tick();
        check({name, "_valid_wait"}, 32'(resp_valid), 32'd0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1 check({name, "_stall_wait"}, 32'(stall), 32'd1);
        tick();
        check({name, "_valid"}, 32'(resp_valid), 32'd1);
        check({name, "_rdata"}, rdata, exp);
    endtask
`endif

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        wen   = 4'h0;
        addr  = 32'h0;
        wdata = 32'h0;
        last_rdata = 32'h0;

        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        tick();
        check("reset_rdata", rdata, 32'h0);
        check("reset_valid", 32'(resp_valid), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);

`ifndef DATA_SRAM_WAIT_EN
        //          en    wen    addr          wdata         valid  rdata
        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'h2, 32'h0000_0010, 32'hAAAAAAAA, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,        1'b1, 32'hDEADAAEF};
        vecs[4]  = '{1'b1, 4'hC, 32'h0000_0012, 32'h12341234, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,        1'b1, 32'h1234AAEF};
        vecs[6]  = '{1'b1, 4'h0, 32'h0000_1010, 32'h0,        1'b1, 32'h1234AAEF};
        vecs[7]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        1'b0, 32'h0};
        vecs[8]  = '{1'b1, 4'h0, 32'h0000_0013, 32'h0,        1'b1, 32'h1234AAEF};
        vecs[9]  = '{1'b1, 4'hF, 32'h0000_0020, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,        1'b1, 32'hCAFEF00D};
        vecs[11] = '{1'b1, 4'h9, 32'h0000_0020, 32'h11223344, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,        1'b1, 32'h11FEF044};
        vecs[13] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h0BADC0DE, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 4'h0, 32'h0000_0FFC, 32'h0,        1'b1, 32'h0BADC0DE};
        vecs[15] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,        1'b1, 32'h1234AAEF};
        vecs[16] = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,        1'b0, 32'h0};
        vecs[17] = '{1'b1, 4'hF, 32'h0000_0044, 32'h55667788, 1'b0, 32'h0};

        for (int i = 0; i < 18; i++) begin
            drive(1'b0, vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].exp_rdata);
            #1 check($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(resp_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                if (exp_q.size() > 0) begin
                    last_rdata = exp_q.pop_front();
                    check($sformatf("vec%0d_rdata", i), rdata, last_rdata);
                end else begin
                    check($sformatf("vec%0d_sb_underflow", i), 32'd0, 32'd1);
                end
            end else begin
                check($sformatf("vec%0d_rdata_hold", i), rdata, last_rdata);
            end
        end
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset beats a simultaneous write; storage survives reset
        drive(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'h0);
        tick();
        check("rst_wr_rdata", rdata, 32'h0);
        check("rst_wr_valid", 32'(resp_valid), 32'd0);
        drive(1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        tick();
        check("post_rst_valid", 32'(resp_valid), 32'd1);
        check("post_rst_rdata", rdata, 32'h1234AAEF);

        // Reset beats a simultaneous read and clears held rdata
        drive(1'b1, 1'b1, 4'h0, 32'h0000_0044, 32'h0);
        tick();
        check("rst_rd_rdata", rdata, 32'h0);
        check("rst_rd_valid", 32'(resp_valid), 32'd0);
        drive(1'b0, 1'b1, 4'h0, 32'h0000_0044, 32'h0);
        tick();
        check("rd_0x44_rdata", rdata, 32'h55667788);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        check("idle_valid", 32'(resp_valid), 32'd0);
        check("idle_rdata_hold", rdata, 32'h55667788);
`else
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();

        // Write with an ignored write presented during the wait cycle
        drive(1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'h1234AAEF);
        #1 check("wr_stall_acc", 32'(stall), 32'd1);
        tick();
        check("wr_valid_wait", 32'(resp_valid), 32'd0);
        drive(1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'hFFFFFFFF);
        #1 check("wr_stall_wait", 32'(stall), 32'd1);
        tick();
        check("wr_no_valid", 32'(resp_valid), 32'd0);
        check("wr_rdata_hold", rdata, 32'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1 check("wr_stall_done", 32'(stall), 32'd0);
        tick();

        // Read with a conflicting write presented during the wait cycle
        drive(1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        #1 check("rd_stall_acc", 32'(stall), 32'd1);
        tick();
        check("rd_valid_wait", 32'(resp_valid), 32'd0);
        drive(1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'h0);
        #1 check("rd_stall_wait", 32'(stall), 32'd1);
        tick();
        check("rd_valid", 32'(resp_valid), 32'd1);
        check("rd_rdata", rdata, 32'h1234AAEF);
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1 check("rd_stall_done", 32'(stall), 32'd0);
        tick();
        check("rd_valid_pulse", 32'(resp_valid), 32'd0);
        check("rd_rdata_hold", rdata, 32'h1234AAEF);
        wait_read("rd_after_ignored", 32'h0000_1010, 32'h1234AAEF);

        // Reset in the wait cycle discards the pending write
        drive(1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'h0);
        tick();
        drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1 check("rst_wait_stall", 32'(stall), 32'd0);
        check("rst_wait_rdata", rdata, 32'h0);
        tick();
        wait_read("rd_after_discard", 32'h0000_0010, 32'h1234AAEF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
